ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_pkg.sv | 27 ++
 rtl/ex_operand_stage_fwd_mux.sv | 36 +++
 rtl/ex_operand_stage.sv | 152 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg -- shared definitions for the ID/EX operand stage.
//   alu_op_e     : ALU operation encodings carried on ALUoperation.
//   idex_ctrl_t  : control/index fields of the ID/EX pipeline register.
//                  The data fields (rs1/rs2 data, immediate) are XLEN wide
//                  and live beside this struct in the top module.
package ex_operand_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       alu_src;
    logic [3:0] aluop;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } idex_ctrl_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux -- forwarding selector for one EX operand.
//   Only built when EX_OPERAND_FORWARDING_EN is defined.
//   rs              : source register index held in ID/EX
//   reg_data        : source data held in ID/EX
//   exmem_* / memwb_*: destination, write enable and result of the two
//                     younger pipeline stages
//   fwd_data        : selected operand; EX/MEM beats MEM/WB, x0 never forwards
`ifdef EX_OPERAND_FORWARDING_EN
module fwd_mux #(
  parameter int unsigned XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == rs);
  assign hit_memwb = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == rs);

  always_comb begin
    fwd_data = reg_data;
    if (hit_exmem)      fwd_data = exmem_result;
    else if (hit_memwb) fwd_data = memwb_result;
  end

endmodule
`endif

// File: rtl/ex_operand_stage.sv
// ex_operand_stage -- ID/EX pipeline register with EX operand selection.
//   Inputs : clk, reset (async, active-high), id_* decode fields,
//            exmem_*/memwb_* forwarding sources, stall (hold), flush (bubble).
//   Outputs: ALUoperation, operand1, operand2, store_data, ex_rd,
//            ex_reg_write, ex_mem_read, ex_mem_write, ex_valid,
//            load_use_stall (request to hold IF/ID).
//   Macro  : EX_OPERAND_FORWARDING_EN enables the forwarding muxes; without
//            it operands come straight from the register and every RAW
//            hazard against EX or EX/MEM is resolved by stalling.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_alu_src,
  input  logic [3:0]      id_ALUoperation,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            stall,
  input  logic            flush,
  output logic [3:0]      ALUoperation,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_valid,
  output logic            load_use_stall
);

  idex_ctrl_t      ctrl_q;
  idex_ctrl_t      ctrl_d;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            load_hazard;

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.valid     = id_valid;
    ctrl_d.rs1       = id_rs1;
    ctrl_d.rs2       = id_rs2;
    ctrl_d.rd        = id_rd;
    ctrl_d.alu_src   = id_alu_src;
    ctrl_d.aluop     = id_ALUoperation;
    ctrl_d.reg_write = id_reg_write;
    ctrl_d.mem_read  = id_mem_read;
    ctrl_d.mem_write = id_mem_write;
  end

  // A load in EX cannot forward its data yet: the consumer in ID waits a cycle.
  assign load_hazard = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != '0) &
                       id_valid & ((ctrl_q.rd == id_rs1) | (ctrl_q.rd == id_rs2));

`ifdef EX_OPERAND_FORWARDING_EN
  assign load_use_stall = load_hazard;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs              (ctrl_q.rs1),
    .reg_data        (rs1_data_q),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs              (ctrl_q.rs2),
    .reg_data        (rs2_data_q),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .fwd_data        (rs2_fwd)
  );
`else
  logic ex_raw;
  logic exmem_raw;
  logic unused_fwd;

  // Without forwarding, any pending write to a source held in EX or EX/MEM
  // must retire before the consumer may leave ID.
  assign ex_raw    = ctrl_q.reg_write & (ctrl_q.rd != '0) &
                     ((ctrl_q.rd == id_rs1) | (ctrl_q.rd == id_rs2));
  assign exmem_raw = exmem_reg_write & (exmem_rd != '0) &
                     ((exmem_rd == id_rs1) | (exmem_rd == id_rs2));

  assign load_use_stall = load_hazard | ex_raw | exmem_raw;

  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  assign unused_fwd = ^{exmem_result, memwb_rd, memwb_reg_write, memwb_result,
                        ctrl_q.rs1, ctrl_q.rs2};
`endif

  // flush outranks stall; a load-use bubble only applies when not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (flush || (!stall && load_use_stall)) begin
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!stall) begin
      ctrl_q     <= ctrl_d;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
    end
  end

  assign ALUoperation = ctrl_q.aluop;
  assign ex_rd        = ctrl_q.rd;
  assign ex_reg_write = ctrl_q.reg_write;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_valid     = ctrl_q.valid;
  assign operand1     = rs1_fwd;
  assign operand2     = ctrl_q.alu_src ? imm_q : rs2_fwd;
  assign store_data   = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage -- directed bench for ex_operand_stage (XLEN=32).
//   Table of one-instruction vectors plus hand-written reset and load-use
//   sequences. Expectations follow EX_OPERAND_FORWARDING_EN when defined.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

`ifdef EX_OPERAND_FORWARDING_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_ALUoperation;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, flush;
  logic [3:0]  ALUoperation;
  logic [31:0] operand1, operand2, store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, load_use_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_ALUoperation(id_ALUoperation),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .stall(stall), .flush(flush),
    .ALUoperation(ALUoperation), .operand1(operand1), .operand2(operand2),
    .store_data(store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_valid(ex_valid),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alu_src;
    logic [3:0]  op;
    logic        regw, memr, memw, valid, stl, fls;
    logic [4:0]  xrd;
    logic        xwe;
    logic [31:0] xres;
    logic [4:0]  wrd;
    logic        wwe;
    logic [31:0] wres;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_op1, e_op2, e_st;
    logic        e_rw;
    logic        data_ok;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_idle();
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
  endtask

  task automatic id_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_src = 1'b0;
    id_ALUoperation = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
  endtask

  initial begin
    // rs1 rs2 rd | d1 d2 imm | alu_src op | regw memr memw valid stall flush |
    // exmem rd/we/res | memwb rd/we/res | exp valid op rd op1 op2 store regw data_ok
    vt[0] = '{5, 6, 7, 10, 20, 0, 0, ALU_ADD, 1, 0, 0, 1, 0, 0,
              5, 1, 77, 0, 0, 0,
              1, ALU_ADD, 7, F ? 32'd77 : 32'd10, 20, 20, 1, 1};
    vt[1] = '{3, 3, 8, 100, 200, 0, 0, ALU_SUB, 1, 0, 0, 1, 0, 0,
              3, 1, 1, 3, 1, 2,
              1, ALU_SUB, 8, F ? 32'd1 : 32'd100, F ? 32'd1 : 32'd200, F ? 32'd1 : 32'd200, 1, 1};
    vt[2] = '{0, 0, 9, 11, 22, 0, 0, ALU_AND, 1, 0, 0, 1, 0, 0,
              0, 1, 1, 0, 1, 2,
              1, ALU_AND, 9, 11, 22, 22, 1, 1};
    vt[3] = '{10, 11, 12, 5, 6, 0, 0, ALU_OR, 1, 0, 0, 1, 0, 0,
              10, 0, 99, 11, 1, 32'hABCD,
              1, ALU_OR, 12, 5, F ? 32'hABCD : 32'd6, F ? 32'hABCD : 32'd6, 1, 1};
    vt[4] = '{1, 2, 13, 3, 4, 32'hFFFF_FFFC, 1, ALU_ADD, 0, 0, 1, 1, 0, 0,
              2, 1, 32'h55, 0, 0, 0,
              1, ALU_ADD, 13, 3, 32'hFFFF_FFFC, F ? 32'h55 : 32'd4, 0, 1};
    vt[5] = '{14, 16, 15, 999, 888, 0, 0, ALU_SUB, 1, 0, 0, 1, 1, 0,
              2, 1, 32'h66, 0, 0, 0,
              1, ALU_ADD, 13, 3, 32'hFFFF_FFFC, F ? 32'h66 : 32'd4, 0, 1};
    vt[6] = '{1, 2, 21, 1, 2, 3, 0, ALU_ADD, 1, 0, 0, 1, 1, 1,
              0, 0, 0, 0, 0, 0,
              0, ALU_AND, 0, 0, 0, 0, 0, 0};
    vt[7] = '{1, 2, 22, 5, 5, 5, 0, ALU_SUB, 1, 1, 0, 1, 1, 0,
              0, 0, 0, 0, 0, 0,
              0, ALU_AND, 0, 0, 0, 0, 0, 0};
    vt[8] = '{1, 2, 20, 7, 8, 0, 0, ALU_ADD, 1, 0, 0, 1, 0, 0,
              0, 0, 0, 0, 0, 0,
              1, ALU_ADD, 20, 7, 8, 8, 1, 1};

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_idle();
    fwd_idle();
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_regw", ex_reg_write, 0);
    chk("rst_memr", ex_mem_read, 0);
    chk("rst_memw", ex_mem_write, 0);
    chk("rst_aluop", ALUoperation, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_op2", operand2, 0);
    chk("rst_lus", load_use_stall, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      fwd_idle();
      id_valid = vt[i].valid; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rd = vt[i].rd;
      id_rs1_data = vt[i].d1; id_rs2_data = vt[i].d2; id_imm = vt[i].imm;
      id_alu_src = vt[i].alu_src; id_ALUoperation = vt[i].op;
      id_reg_write = vt[i].regw; id_mem_read = vt[i].memr; id_mem_write = vt[i].memw;
      stall = vt[i].stl; flush = vt[i].fls;
      tick();
      stall = 1'b0; flush = 1'b0;
      id_idle();
      exmem_rd = vt[i].xrd; exmem_reg_write = vt[i].xwe; exmem_result = vt[i].xres;
      memwb_rd = vt[i].wrd; memwb_reg_write = vt[i].wwe; memwb_result = vt[i].wres;
      #1;
      chk($sformatf("v%0d_valid", i), ex_valid, vt[i].e_valid);
      chk($sformatf("v%0d_aluop", i), ALUoperation, vt[i].e_op);
      chk($sformatf("v%0d_rd", i), ex_rd, vt[i].e_rd);
      chk($sformatf("v%0d_regw", i), ex_reg_write, vt[i].e_rw);
      chk($sformatf("v%0d_lus", i), load_use_stall, 0);
      if (vt[i].data_ok) begin
        chk($sformatf("v%0d_op1", i), operand1, vt[i].e_op1);
        chk($sformatf("v%0d_op2", i), operand2, vt[i].e_op2);
        chk($sformatf("v%0d_store", i), store_data, vt[i].e_st);
      end
    end

    // Reset between edges with a valid ADD in the register.
    fwd_idle();
    #1;
    chk("mid_pre_valid", ex_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_valid", ex_valid, 0);
    chk("mid_op1", operand1, 0);
    chk("mid_aluop", ALUoperation, 0);
    chk("mid_rd", ex_rd, 0);
    #2;
    reset = 1'b0;
    tick();

    // Load-use: LW x4 in EX, consumer reads rs2=x4.
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd0; id_rd = 5'd4;
    id_rs1_data = 32'd100; id_imm = 32'd8; id_alu_src = 1'b1;
    id_ALUoperation = ALU_ADD; id_reg_write = 1'b1; id_mem_read = 1'b1;
    tick();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd4; id_rd = 5'd6;
    id_rs1_data = 32'd3; id_rs2_data = 32'hDEAD; id_imm = '0; id_alu_src = 1'b0;
    id_ALUoperation = ALU_ADD; id_reg_write = 1'b1; id_mem_read = 1'b0;
    #1;
    chk("lu_memr", ex_mem_read, 1);
    chk("lu_stall", load_use_stall, 1);
    tick();
    exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'd0;
    #1;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_stall", load_use_stall, F ? 0 : 1);
`ifndef EX_OPERAND_FORWARDING_EN
    tick();
    fwd_idle();
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'h1234;
    #1;
    chk("lu_bubble2_valid", ex_valid, 0);
    chk("lu_bubble2_stall", load_use_stall, 0);
`endif
    tick();
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'h1234;
    id_idle();
    #1;
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 6);
    chk("lu_issue_op1", operand1, 3);
    chk("lu_issue_op2", operand2, F ? 32'h1234 : 32'hDEAD);
    chk("lu_issue_store", store_data, F ? 32'h1234 : 32'hDEAD);
    chk("lu_issue_stall", load_use_stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
